// File: rtl/alu_nibble_seq.sv
// Wide ALU sequencer: runs 4*NIB-bit ops one nibble per cycle on a 4-bit ALU.
// Carry chains LSB-first; SUB chains through ADD with inverted B.
module alu_4b (
    input  logic [2:0] s,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] f,
    output logic       cout
);
    logic [4:0] sum;

    always_comb begin
        sum  = 5'd0;
        f    = 4'd0;
        cout = 1'b0;
        case (s)
            3'b000: f = a;
            3'b001: begin
                sum  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
                f    = sum[3:0];
                cout = sum[4];
            end
            3'b010: begin
                // SUB always forces Cin=1, so it cannot take a chained carry
                sum  = {1'b0, a} + {1'b0, ~b} + 5'd1;
                f    = sum[3:0];
                cout = sum[4];
            end
            3'b011: f = a & b;
            3'b100: f = a | b;
            3'b101: f = a ^ b;
            3'b110: f = ~a;
            default: f = 4'd0;
        endcase
    end
endmodule

module alu_nibble_seq #(
    parameter int NIB = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [4*NIB-1:0] req_a,
    input  logic [4*NIB-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [4*NIB-1:0] rsp_f,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic             busy
);
    localparam int W  = 4 * NIB;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [2:0]      op_q;
    logic [W-1:0]    a_q, b_q;
    logic [IW-1:0]   idx;
    logic            carry;

    logic [3:0]      a_nib, b_nib, alu_b, alu_f;
    logic [2:0]      alu_s;
    logic            alu_cin, alu_cout;
    logic            is_arith, last;
    logic [W-1:0]    f_next;

    assign a_nib    = a_q[{idx, 2'b00} +: 4];
    assign b_nib    = b_q[{idx, 2'b00} +: 4];
    assign is_arith = (op_q == 3'b001) || (op_q == 3'b010);
    assign last     = (idx == IW'(NIB - 1));
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        alu_s   = op_q;
        alu_b   = b_nib;
        alu_cin = 1'b0;
        case (op_q)
            3'b001: alu_cin = (idx == '0) ? 1'b0 : carry;
            3'b010: begin
                if (idx != '0) begin
                    alu_s   = 3'b001;
                    alu_b   = ~b_nib;
                    alu_cin = carry;
                end
            end
            default: ;
        endcase
    end

    alu_4b u_alu (
        .s    (alu_s),
        .a    (a_nib),
        .b    (alu_b),
        .cin  (alu_cin),
        .f    (alu_f),
        .cout (alu_cout)
    );

    always_comb begin
        f_next = rsp_f;
        f_next[{idx, 2'b00} +: 4] = alu_f;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = EXEC;
            EXEC:    if (last) state_nx = DONE;
            DONE:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_f       <= '0;
            rsp_cout    <= 1'b0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        a_q   <= req_a;
                        b_q   <= req_b;
                        idx   <= '0;
                        carry <= 1'b0;
                        rsp_f <= '0;
                    end
                end
                EXEC: begin
                    rsp_f <= f_next;
                    carry <= is_arith ? alu_cout : 1'b0;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        rsp_cout    <= is_arith ? alu_cout : 1'b0;
                        rsp_zero    <= (f_next == '0);
                        rsp_illegal <= (op_q == 3'b111);
                        rsp_valid   <= 1'b1;
                    end
                end
                DONE: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
